// File: rtl/fp_pkg.sv
// Shared single-precision field constants and converter state encoding.
// Used by int_to_float (optional I2F_UNSIGNED_EN selects unsigned input).
package fp_pkg;

   localparam int FP_BIAS  = 127;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   localparam int FP_SIGN_BIT = 31;
   localparam int FP_EXP_HI   = 30;
   localparam int FP_EXP_LO   = 23;
   localparam int FP_MAN_HI   = 22;
   localparam int FP_MAN_LO   = 0;

   localparam logic [31:0] FP_POS_ZERO = 32'h00000000;

   typedef enum logic [2:0] {
      ST_GET_A     = 3'd0,
      ST_CONVERT_0 = 3'd1,
      ST_NORMALISE = 3'd2,
      ST_ROUND     = 3'd3,
      ST_PACK      = 3'd4,
      ST_PUT_Z     = 3'd5
   } i2f_state_t;

endpackage

// File: rtl/int_to_float.sv
// 32-bit integer to IEEE-754 single, round-to-nearest-even, stb/ack handshakes.
// Define I2F_UNSIGNED_EN to treat input_a as unsigned.
module int_to_float
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   i2f_state_t state;

   logic [31:0]         a;
   logic [31:0]         value;
   logic [31:0]         z;
   logic [FP_MAN_W:0]   z_m;
   logic [FP_EXP_W-1:0] z_e;
   logic                sign;
   logic                guard;
   logic                round_bit;
   logic                sticky;

   logic [31:0] mag;
   logic        a_neg;
   logic        rnd_up;
   logic [FP_EXP_W-1:0] bias;

   assign bias = FP_EXP_W'(FP_BIAS);

`ifdef I2F_UNSIGNED_EN
   assign a_neg = 1'b0;
   assign mag   = a;
`else
   // Negating 0x80000000 wraps back to itself, which is its correct magnitude.
   assign a_neg = a[31];
   assign mag   = a_neg ? (~a + 32'd1) : a;
`endif

   assign rnd_up = guard && (round_bit || sticky || z_m[0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_GET_A;
         input_a_ack  <= 1'b0;
         output_z_stb <= 1'b0;
         output_z     <= FP_POS_ZERO;
         z            <= FP_POS_ZERO;
         a            <= '0;
         value        <= '0;
         z_m          <= '0;
         z_e          <= '0;
         sign         <= 1'b0;
         guard        <= 1'b0;
         round_bit    <= 1'b0;
         sticky       <= 1'b0;
      end else begin
         unique case (state)
            ST_GET_A: begin
               input_a_ack <= 1'b1;
               if (input_a_ack && input_a_stb) begin
                  a           <= input_a;
                  input_a_ack <= 1'b0;
                  state       <= ST_CONVERT_0;
               end
            end
            ST_CONVERT_0: begin
               if (a == 32'd0) begin
                  z     <= FP_POS_ZERO;
                  state <= ST_PUT_Z;
               end else begin
                  sign  <= a_neg;
                  value <= mag;
                  z_e   <= 8'd31;
                  state <= ST_NORMALISE;
               end
            end
            ST_NORMALISE: begin
               if (!value[31]) begin
                  value <= value << 1;
                  z_e   <= z_e - 8'd1;
               end else begin
                  z_m       <= value[31:8];
                  guard     <= value[7];
                  round_bit <= value[6];
                  sticky    <= |value[5:0];
                  state     <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               // All-ones mantissa wraps to zero: 1.0 at the next exponent.
               if (rnd_up) begin
                  z_m <= z_m + 24'd1;
                  if (z_m == 24'hFFFFFF)
                     z_e <= z_e + 8'd1;
               end
               state <= ST_PACK;
            end
            ST_PACK: begin
               z[FP_MAN_HI:FP_MAN_LO] <= z_m[FP_MAN_W-1:0];
               z[FP_EXP_HI:FP_EXP_LO] <= z_e + bias;
               z[FP_SIGN_BIT]         <= sign;
               state                  <= ST_PUT_Z;
            end
            ST_PUT_Z: begin
               output_z_stb <= 1'b1;
               output_z     <= z;
               if (output_z_stb && output_z_ack) begin
                  output_z_stb <= 1'b0;
                  state        <= ST_GET_A;
               end
            end
            default: state <= ST_GET_A;
         endcase
      end
   end

endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float: vector table plus backpressure and reset cases.
// Build with I2F_UNSIGNED_EN to select the unsigned vector set.
module tb_int_to_float;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   int_to_float dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] z;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] a);
      int n = 0;
      @(negedge clk);
      while (!input_a_ack && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ack_ready", 32'(input_a_ack), 32'd1);
      input_a     = a;
      input_a_stb = 1'b1;
      @(posedge clk);
      #1 input_a_stb = 1'b0;
   endtask

   task automatic wait_stb(input string nm, input int lat);
      int c = 0;
      while (!output_z_stb && c < 80) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk({nm, "_lat"}, 32'(c), 32'(lat));
   endtask

   task automatic take(input string nm);
      @(negedge clk);
      output_z_ack = 1'b1;
      @(posedge clk);
      #1;
      output_z_ack = 1'b0;
      chk({nm, "_stb_drop"}, 32'(output_z_stb), 32'd0);
      chk({nm, "_ack_low"}, 32'(input_a_ack), 32'd0);
      @(posedge clk);
      #1;
      chk({nm, "_ack_rise"}, 32'(input_a_ack), 32'd1);
   endtask

   task automatic conv(input string nm, input vec_t v);
      send(v.a);
      wait_stb(nm, v.lat);
      chk({nm, "_z"}, output_z, v.z);
      take(nm);
   endtask

   initial begin
      vecs.push_back('{32'h00000001, 32'h3F800000, 36});
      vecs.push_back('{32'h00000000, 32'h00000000, 2});
      vecs.push_back('{32'h7FFFFFFF, 32'h4F000000, 6});
      vecs.push_back('{32'h01000001, 32'h4B800000, 12});
      vecs.push_back('{32'h01000003, 32'h4B800002, 12});
      vecs.push_back('{32'h00000003, 32'h40400000, 35});
      vecs.push_back('{32'h00000064, 32'h42C80000, 30});
`ifdef I2F_UNSIGNED_EN
      vecs.push_back('{32'hFFFFFFFF, 32'h4F800000, 5});
      vecs.push_back('{32'h80000000, 32'h4F000000, 5});
`else
      vecs.push_back('{32'hFFFFFFFF, 32'hBF800000, 36});
      vecs.push_back('{32'h80000000, 32'hCF000000, 5});
      vecs.push_back('{32'hFFFFFF00, 32'hC3800000, 28});
`endif

      rst          = 1'b1;
      input_a      = '0;
      input_a_stb  = 1'b0;
      output_z_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stb", 32'(output_z_stb), 32'd0);
      chk("rst_ack", 32'(input_a_ack), 32'd0);
      chk("rst_z", output_z, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         conv($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: result must hold while ack is withheld.
      send(32'h00000064);
      wait_stb("bp", 30);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp_stb_hold", 32'(output_z_stb), 32'd1);
         chk("bp_z_hold", output_z, 32'h42C80000);
      end
      take("bp");

      // Reset in the middle of a long normalise.
      send(32'h00000001);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_stb", 32'(output_z_stb), 32'd0);
      chk("midrst_ack", 32'(input_a_ack), 32'd0);
      chk("midrst_z", output_z, 32'd0);
      rst = 1'b0;
      conv("post_rst", '{32'h01000003, 32'h4B800002, 12});

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/int_to_float.md
Name: int_to_float

Overview:
- Multi-cycle converter from 32-bit two's-complement integer to IEEE-754 single precision, rounded to nearest-even.
- Sits directly upstream of the FPU multiplier: output_z/output_z_stb/output_z_ack wire straight into its input_a or input_b handshake, so integer operands (pixel values, counters, DSP samples) can be scaled in float.
- Uses the same stb/ack operand protocol as the other FPU blocks.

Parameters:
- None. Widths are fixed: 32-bit integer in, 32-bit single out.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- input_a  input  32  integer operand, signed; unsigned when I2F_UNSIGNED_EN is defined
- input_a_stb  input  1  producer: input_a valid
- input_a_ack  output  1  block ready to take input_a
- output_z  output  32  IEEE-754 single result
- output_z_stb  output  1  output_z valid
- output_z_ack  input  1  consumer accepts output_z

Behaviour:
- Reset (rst=1 at a clock edge overrides everything, including mid-conversion): state<=get_a, input_a_ack=0, output_z_stb=0, output_z=0, internal z=0. An in-flight operand is discarded.
- States: get_a, convert_0, normalise, round, pack, put_z. Encoded in 3 bits.
- get_a:
  - Registers input_a_ack<=1.
  - On an edge with input_a_ack && input_a_stb: latch input_a, input_a_ack<=0, go to convert_0.
  - Ack rises one cycle after entering get_a.
- convert_0:
  - Input == 0 → z=0x00000000 (+0), go to put_z.
  - Otherwise: sign <= a[31]; value <= |a| as 32-bit unsigned. 0x80000000 gives magnitude 0x80000000, with no overflow.
  - z_e <= 31 (unbiased, 8-bit signed-safe register). Go to normalise.
- normalise:
  - If value[31]=0: value<<=1, z_e<=z_e-1, stay. One bit per cycle.
  - Else: z_m<=value[31:8], guard<=value[7], round_bit<=value[6], sticky<=|value[5:0]; go to round.
  - Takes 1..32 cycles (1 when bit31 is already set; 32 for input 1).
- round:
  - If guard && (round_bit | sticky | z_m[0]): z_m<=z_m+1.
  - If z_m==24'hFFFFFF at the same time, also z_e<=z_e+1. The wrapped mantissa 0 encodes 1.0·2^(e+1).
  - Go to pack.
- pack:
  - z[22:0]<=z_m[22:0], z[30:23]<=z_e+127, z[31]<=sign. Go to put_z.
  - Overflow, denormals, NaN and Inf cannot occur; the maximum exponent is 31 (32 unsigned).
- put_z:
  - output_z_stb<=1, output_z<=z.
  - On an edge with output_z_stb && output_z_ack: output_z_stb<=0, go to get_a.
  - output_z is held stable while stb is high and ack is low (full backpressure, no timeout).
  - output_z keeps its last value after the handshake until the next put_z.
- Latency, accept edge to first stb-high edge: 5 + shift count cycles (5..36). Throughput is one conversion per transaction; no overlap between input and output handshakes.
- Ack and stb are registered; nothing combinational runs from input to output.

Optional Feature:
- I2F_UNSIGNED_EN defined:
  - input_a is unsigned. sign is forced to 0 and the magnitude is input_a unchanged.
  - Max exponent becomes 31, with rounding up to 32 (0xFFFFFFFF → 0x4F800000).
- Not defined: signed two's-complement behaviour as above.

Decomposition:
- Shared package fp_pkg:
  - FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23.
  - Field index localparams.
  - FP_POS_ZERO=32'h00000000.
  - Converter state encoding constants.
- No sub-module is required. The RNE round step is a candidate for a later shared fp_round_rne, but it stays inline here.

Test Plan:
- input 0x00000001 → 0x3F800000 after 32 normalise cycles.
- input 0xFFFFFFFF (−1) → 0xBF800000; input 0 → 0x00000000 via the convert_0 shortcut.
- input 0x80000000 → 0xCF000000.
- input 0x7FFFFFFF → 0x4F000000, exercising round carry into the exponent.
- input 0x01000001 → 0x4B800000 (tie to even, down); 0x01000003 → 0x4B800002 (tie to even, up).
- Backpressure: hold output_z_ack=0 for 10 cycles → stb and output_z stay constant; ack=1 → stb drops next edge, input_a_ack rises one cycle later.
- Reset mid-normalise: assert rst → next edge gives stb=0, ack=0, output_z=0, state get_a; a following conversion is correct.
- With I2F_UNSIGNED_EN defined: 0xFFFFFFFF → 0x4F800000.
